alu: RTL
========

# alu

8-bit ALU and processor-status stage of the microcode 65C02 core, directly downstream of the register file. It consumes the register-file read port (`R`) and the memory/operand bus (`M`), and produces a registered result `OUT` that feeds the register-file write data and address logic. It also maintains the registered status byte `P` (NV-BDIZC) and evaluates branch conditions from it.

## Interface
- No parameters.
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  synchronous reset, active low
- `en`  in  1  stage enable (RDY); low = all registers hold
- `R`  in  8  register-file read data
- `M`  in  8  operand / memory data
- `op`  in  4  ALU operation (see Operation)
- `ci_sel`  in  2  carry-in: 00=0, 01=1, 10=P.C, 11=CO
- `fl`  in  3  flag update select
- `bcd`  in  1  permit decimal mode for this op (ADC/SBC only)
- `cond`  in  3  branch condition select
- `OUT`  out  8  registered result
- `CO`  out  1  registered carry-out of the last enabled op
- `P`  out  8  status register
- `take`  out  1  combinational branch condition from current `P`

## Operation
- `op` encoding:
  - 0 OR `R|M`
  - 1 AND
  - 2 EOR
  - 3 ADC `R+M+ci`
  - 4 SBC `R+~M+ci`
  - 5 PASS M
  - 6 PASS R
  - 7 SHL `{R[6:0],ci}`, c=R[7]
  - 8 SHR `{ci,R[7:1]}`, c=R[0]
  - 9 TRB `M&~R`
  - A-F reserved, behave as PASS R with c=0.
- Logic ops and PASS/TRB: carry-out c=0. ADC/SBC: c = bit-8 carry (SBC carry = no borrow).
- V (ADC/SBC only): `(R7==M'7) && (res7!=R7)`, where M' is M for ADC and ~M for SBC.
- Decimal mode is active when `bcd && P[3]` and op is 3 or 4.
  - ADC: lo=R[3:0]+M[3:0]+ci; if lo>9 then lo+=6 and carry into the high nibble. hi=R[7:4]+M[7:4]+hc. V is taken from hi before adjust. If hi>9 then hi+=6 and c=1.
  - SBC: do the binary subtract. If the low nibble borrowed, subtract 6 from it. If the high nibble borrowed, subtract 0x60 and set c=0.
  - N and Z are taken from the adjusted result.
- `fl` selects the flag update (applied only when `en` is high):
  - 000 hold
  - 001 NZ from result
  - 010 NZC
  - 011 NVZC
  - 100 BIT: Z=(R&M)==0, N=M[7], V=M[6]
  - 101 P ← M with P[5:4] forced to 11
  - 110 interrupt entry: I=1, D=0
  - 111 single bit: P[op[2:0]] ← op[3]. Covers CLC/SEC/CLI/SEI/CLD/SED/CLV. In this mode OUT and CO hold.
- Bits 5 and 4 of P always read 1.
- `take`, selected by `cond`: 0 N=0, 1 N=1, 2 V=0, 3 V=1, 4 C=0, 5 C=1, 6 Z=0, 7 Z=1.
- Reset values: OUT=0x00, CO=0, P=0x34 (I=1, D=0).

## Timing
- Latency: 1 cycle. Inputs sampled at edge n produce OUT/CO/P after edge n. No combinational path from inputs to OUT or P.
- `take` is combinational from registered P only. It reflects flags written on the previous enabled edge.
- `ci_sel`=11 uses the CO register from the previous enabled op. This supports address high-byte carry chains, including across `en`-low stall cycles.
- `en`=0: OUT, CO and P all hold, regardless of `op` and `fl`.
- Reset has priority over `en`. A reset asserted in the middle of a sequence returns to reset values on the next edge.
- Simultaneous flag write and carry use: for `ci_sel`=10 the ALU uses P.C before this edge's update.

## Test plan
- Reset: hold `rst_n`=0 for 2 clocks with `en`=1 and random inputs → OUT=0x00, CO=0, P=0x34. Release, then issue PASS M, M=0x00, fl=001 → OUT=0x00, P=0x36.
- Binary ADC: R=0x50, M=0x50, ci_sel=00, fl=011, D=0 → OUT=0xA0, C=0, V=1, N=1, Z=0. Then R=0xFF, M=0x01 → OUT=0x00, C=1, Z=1, V=0.
- Decimal: SED via fl=111, op=0xB. Then ADC R=0x58, M=0x46, ci_sel=01, bcd=1 → OUT=0x05, C=1. Then SBC R=0x12, M=0x21, ci_sel=01 → OUT=0x91, C=0, N=1. Repeat with bcd=0 → OUT=0xF1.
- Shift/carry chain: P.C=1, SHR R=0x01, ci_sel=10, fl=010 → OUT=0x80, C=1, N=1. Then ADC R=0x12, M=0x00, ci_sel=11 → OUT=0x13.
- Stall: while `en`=0 for 3 cycles with changing op/fl/M, OUT, CO and P stay unchanged. Raise `en` → the pending op completes in 1 cycle.
- Status/branch: fl=101, M=0x00 → P=0x30 and take(cond=7)=0. Then CMP-style SBC R=0x40, M=0x40, ci_sel=01, fl=010 → Z=1, C=1, take(cond=7)=1. Then fl=110 → P=0x37.

Source files
------------

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit ALU and NV-BDIZC status stage of the microcode 65C02 core
// One-cycle registered result/carry/status; branch condition decoded from registered P.
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] R,
    input  logic [7:0] M,
    input  logic [3:0] op,
    input  logic [1:0] ci_sel,
    input  logic [2:0] fl,
    input  logic       bcd,
    input  logic [2:0] cond,
    output logic [7:0] OUT,
    output logic       CO,
    output logic [7:0] P,
    output logic       take
);

    logic [7:0] out_q, out_d;
    logic       co_q, co_d;
    logic [7:0] p_q, p_d;

    logic       ci;
    logic [7:0] m_eff;
    logic [8:0] bin;
    logic [4:0] lo5, hi5;
    logic [3:0] lo_adj, hi_adj;
    logic       hc, dec;
    logic [7:0] res;
    logic       c, v;
    logic       flag;

    always_comb begin
        unique case (ci_sel)
            2'b00:   ci = 1'b0;
            2'b01:   ci = 1'b1;
            2'b10:   ci = p_q[0];
            default: ci = co_q;
        endcase

        m_eff  = (op == 4'd4) ? ~M : M;
        bin    = {1'b0, R} + {1'b0, m_eff} + {8'd0, ci};
        dec    = bcd && p_q[3] && ((op == 4'd3) || (op == 4'd4));
        // lo5[4] clear on SBC means the low nibble borrowed
        lo5    = {1'b0, R[3:0]} + {1'b0, m_eff[3:0]} + {4'd0, ci};
        hc     = lo5 > 5'd9;
        lo_adj = hc ? (lo5[3:0] + 4'd6) : lo5[3:0];
        hi5    = {1'b0, R[7:4]} + {1'b0, M[7:4]} + {4'd0, hc};
        hi_adj = (hi5 > 5'd9) ? (hi5[3:0] + 4'd6) : hi5[3:0];

        res = R;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            4'd0: res = R | M;
            4'd1: res = R & M;
            4'd2: res = R ^ M;
            4'd3, 4'd4: begin
                res = bin[7:0];
                c   = bin[8];
                v   = (R[7] == m_eff[7]) && (bin[7] != R[7]);
                if (dec && (op == 4'd3)) begin
                    res = {hi_adj, lo_adj};
                    c   = hi5 > 5'd9;
                    v   = (R[7] == M[7]) && (hi5[3] != R[7]);
                end else if (dec) begin
                    if (!lo5[4]) res[3:0] = res[3:0] - 4'd6;
                    if (!bin[8]) res[7:4] = res[7:4] - 4'd6;
                end
            end
            4'd5: res = M;
            4'd6: res = R;
            4'd7: begin
                res = {R[6:0], ci};
                c   = R[7];
            end
            4'd8: begin
                res = {ci, R[7:1]};
                c   = R[0];
            end
            4'd9: res = M & ~R;
            default: res = R;
        endcase
    end

    always_comb begin
        p_d = p_q;
        case (fl)
            3'b001: begin
                p_d[7] = res[7];
                p_d[1] = res == 8'd0;
            end
            3'b010: begin
                p_d[7] = res[7];
                p_d[1] = res == 8'd0;
                p_d[0] = c;
            end
            3'b011: begin
                p_d[7] = res[7];
                p_d[6] = v;
                p_d[1] = res == 8'd0;
                p_d[0] = c;
            end
            3'b100: begin
                p_d[7] = M[7];
                p_d[6] = M[6];
                p_d[1] = (R & M) == 8'd0;
            end
            3'b101: p_d = M;
            3'b110: begin
                p_d[2] = 1'b1;
                p_d[3] = 1'b0;
            end
            3'b111: p_d[op[2:0]] = op[3];
            default: p_d = p_q;
        endcase
        p_d[5:4] = 2'b11;

        // Single-bit flag ops leave the datapath result untouched
        out_d = (fl == 3'b111) ? out_q : res;
        co_d  = (fl == 3'b111) ? co_q : c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= 8'h00;
            co_q  <= 1'b0;
            p_q   <= 8'h34;
        end else if (en) begin
            out_q <= out_d;
            co_q  <= co_d;
            p_q   <= p_d;
        end
    end

    always_comb begin
        unique case (cond[2:1])
            2'd0:    flag = p_q[7];
            2'd1:    flag = p_q[6];
            2'd2:    flag = p_q[0];
            default: flag = p_q[1];
        endcase
        take = flag == cond[0];
    end

    assign OUT = out_q;
    assign CO  = co_q;
    assign P   = p_q;

endmodule
